aggr_seq: RTL



---
 rtl/aggr_seq.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/aggr_seq.sv
// aggr_seq: sequential GNN neighbour aggregator.
// Takes one batch of node feature vectors and an adjacency matrix. For each
// destination node it reduces the features of its source nodes, either by
// sum or by unsigned max. One source node is processed per clock.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   in_valid/in_ready batch handshake for x_in, adj_in, mode_max
//   x_in              node n, feature f at bit (n*NUM_FEAT+f)*AGGR_IN_SIZE
//   adj_in            bit d*NUM_NODES+s set: dest d aggregates source s
//   mode_max          0 = sum, 1 = unsigned max
//   out_valid/out_ready result handshake for x_aggr
//   x_aggr            same packing as x_in, AGGR_OUT_SIZE bits per element
module aggr_seq #(
  parameter int unsigned NUM_NODES     = 4,
  parameter int unsigned NUM_FEAT      = 4,
  parameter int unsigned AGGR_IN_SIZE  = 5,
  localparam int unsigned AGGR_OUT_SIZE = AGGR_IN_SIZE + $clog2(NUM_NODES)
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic [NUM_NODES*NUM_FEAT*AGGR_IN_SIZE-1:0]    x_in,
  input  logic [NUM_NODES*NUM_NODES-1:0]                adj_in,
  input  logic                                          mode_max,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [NUM_NODES*NUM_FEAT*AGGR_OUT_SIZE-1:0]   x_aggr
);

  localparam int unsigned SRC_W = $clog2(NUM_NODES);
  localparam int unsigned ROW_W = NUM_FEAT * AGGR_IN_SIZE;
  localparam int unsigned X_W   = NUM_NODES * ROW_W;
  localparam int unsigned ADJ_W = NUM_NODES * NUM_NODES;
  localparam int unsigned ACC_W = NUM_NODES * NUM_FEAT * AGGR_OUT_SIZE;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [SRC_W-1:0]   src_q, src_d;
  logic [X_W-1:0]     x_q, x_d;
  logic [ADJ_W-1:0]   adj_q, adj_d;
  logic               mode_q, mode_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   aggr_q, aggr_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;

  // Current source row and adjacency column, selected by src_q
  logic [ROW_W-1:0]     src_row;
  logic [NUM_NODES-1:0] adj_col;
  logic [AGGR_OUT_SIZE-1:0] cur;
  logic [AGGR_OUT_SIZE-1:0] xv;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      src_q       <= '0;
      x_q         <= '0;
      adj_q       <= '0;
      mode_q      <= 1'b0;
      acc_q       <= '0;
      aggr_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      x_q         <= x_d;
      adj_q       <= adj_d;
      mode_q      <= mode_d;
      acc_q       <= acc_d;
      aggr_q      <= aggr_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state, accumulation and registered handshake outputs
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    x_d     = x_q;
    adj_d   = adj_q;
    mode_d  = mode_q;
    acc_d   = acc_q;
    aggr_d  = aggr_q;
    src_row = '0;
    adj_col = '0;
    cur     = '0;
    xv      = '0;

    // Constant-index mux keeps every select statically bounded
    for (int unsigned s = 0; s < NUM_NODES; s++) begin
      if (src_q == SRC_W'(s)) begin
        src_row = x_q[s*ROW_W +: ROW_W];
        for (int unsigned d = 0; d < NUM_NODES; d++) begin
          adj_col[d] = adj_q[d*NUM_NODES + s];
        end
      end
    end

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          x_d     = x_in;
          adj_d   = adj_in;
          mode_d  = mode_max;
          acc_d   = '0;
          src_d   = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        for (int unsigned d = 0; d < NUM_NODES; d++) begin
          for (int unsigned f = 0; f < NUM_FEAT; f++) begin
            if (adj_col[d]) begin
              cur = acc_q[(d*NUM_FEAT+f)*AGGR_OUT_SIZE +: AGGR_OUT_SIZE];
              xv  = AGGR_OUT_SIZE'(src_row[f*AGGR_IN_SIZE +: AGGR_IN_SIZE]);
              if (mode_q) begin
                acc_d[(d*NUM_FEAT+f)*AGGR_OUT_SIZE +: AGGR_OUT_SIZE] = (xv > cur) ? xv : cur;
              end else begin
                acc_d[(d*NUM_FEAT+f)*AGGR_OUT_SIZE +: AGGR_OUT_SIZE] = cur + xv;
              end
            end
          end
        end
        src_d = src_q + 1'b1;
        if (src_q == SRC_W'(NUM_NODES-1)) begin
          // Result is latched separately so x_aggr survives the next capture
          src_d   = '0;
          aggr_d  = acc_d;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign x_aggr    = aggr_q;

endmodule
